adc_pulse_pattern_gen: RTL and testbench

Synthetic ADC stream source that drives the three-channel, two-samples-per-word ADC data interface with a programmed pulse sequence: a pulse on channel A, then B, then C, at programmable spacing. It sits in front of the pulse-timing trigger logic in place of the JESD ADC outputs, selected by a board-level mux, so time-of-flight measurement can be checked in-system with known delays.

---
 rtl/adc_pulse_pattern_gen.sv | 138 +++++++++++++
 tb/tb_adc_pulse_pattern_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pulse_pattern_gen.sv
// adc_pulse_pattern_gen: synthetic three-channel ADC source emitting pulse A, B, C at programmed spacing.
// Define PULSE_GEN_NOISE_EN to add LFSR dither of -8..+7 to every sample.
module adc_pulse_pattern_gen #(
  parameter int ADC_DATA_WIDTH = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          gen_enable,
  input  logic                          gen_start,
  input  logic                          gen_repeat,
  input  logic signed [ADC_DATA_WIDTH-1:0] baseline,
  input  logic signed [ADC_DATA_WIDTH-1:0] amp_a,
  input  logic signed [ADC_DATA_WIDTH-1:0] amp_b,
  input  logic signed [ADC_DATA_WIDTH-1:0] amp_c,
  input  logic [CNT_WIDTH-1:0]          arm_dly,
  input  logic [CNT_WIDTH-1:0]          pulse_width,
  input  logic [CNT_WIDTH-1:0]          gap_ab,
  input  logic [CNT_WIDTH-1:0]          gap_bc,
  output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_a,
  output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_b,
  output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_c,
  output logic                          adc_valid_a,
  output logic                          adc_valid_b,
  output logic                          adc_valid_c,
  output logic                          mark_a,
  output logic                          mark_b,
  output logic                          mark_c,
  output logic                          busy,
  output logic [15:0]                   seq_count
);
  localparam int DW   = ADC_DATA_WIDTH;
  localparam int SMAX = 2 ** (DW - 1) - 1;
  localparam int SMIN = -(2 ** (DW - 1));
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_PA, S_GAB, S_PB, S_GBC, S_PC, S_DONE} state_t;
  state_t r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt, r_arm, r_pw, r_gab, r_gbc, w_wm1;
  logic signed [DW-1:0] r_base, r_amp_a, r_amp_b, r_amp_c, w_base;
  logic signed [DW+1:0] w_noise, w_sum_0, w_sum_a, w_sum_b, w_sum_c;
  logic w_load;

  function automatic logic [DW-1:0] sat(input logic signed [DW+1:0] v);
    return (v > SMAX) ? DW'(SMAX) : (v < SMIN) ? DW'(SMIN) : v[DW-1:0];
  endfunction

`ifdef PULSE_GEN_NOISE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_lfsr <= 16'hACE1;
    else r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_noise = {{(DW - 2){r_lfsr[3]}}, r_lfsr[3:0]};
`else
  assign w_noise = '0;
`endif

  // the sample leaving on the start edge already belongs to the newly latched config
  assign w_load  = (r_state == S_IDLE) && (w_next == S_ARM);
  assign w_base  = w_load ? baseline : r_base;
  assign w_sum_0 = w_base + w_noise;
  assign w_sum_a = w_sum_0 + r_amp_a;
  assign w_sum_b = w_sum_0 + r_amp_b;
  assign w_sum_c = w_sum_0 + r_amp_c;
  assign w_wm1   = (r_pw == '0) ? '0 : r_pw - CNT_WIDTH'(1);

  // counter holds remaining cycles minus one; a zero gap bypasses its state entirely
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt - CNT_WIDTH'(1);
    case (r_state)
      S_IDLE: if (gen_start) begin w_next = S_ARM; w_cnt = arm_dly; end
      S_ARM:  if (r_cnt == '0) begin w_next = S_PA; w_cnt = w_wm1; end
      S_PA:   if (r_cnt == '0) begin
        w_next = (r_gab == '0) ? S_PB : S_GAB;
        w_cnt  = (r_gab == '0) ? w_wm1 : r_gab - CNT_WIDTH'(1);
      end
      S_GAB:  if (r_cnt == '0) begin w_next = S_PB; w_cnt = w_wm1; end
      S_PB:   if (r_cnt == '0) begin
        w_next = (r_gbc == '0) ? S_PC : S_GBC;
        w_cnt  = (r_gbc == '0) ? w_wm1 : r_gbc - CNT_WIDTH'(1);
      end
      S_GBC:  if (r_cnt == '0) begin w_next = S_PC; w_cnt = w_wm1; end
      S_PC:   if (r_cnt == '0) begin w_next = S_DONE; w_cnt = '0; end
      S_DONE: begin w_next = gen_repeat ? S_ARM : S_IDLE; w_cnt = r_arm; end
      default: w_next = S_IDLE;
    endcase
    if (!gen_enable) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_arm       <= '0;
      r_pw        <= '0;
      r_gab       <= '0;
      r_gbc       <= '0;
      r_base      <= '0;
      r_amp_a     <= '0;
      r_amp_b     <= '0;
      r_amp_c     <= '0;
      adc_data_a  <= '0;
      adc_data_b  <= '0;
      adc_data_c  <= '0;
      adc_valid_a <= 1'b0;
      adc_valid_b <= 1'b0;
      adc_valid_c <= 1'b0;
      mark_a      <= 1'b0;
      mark_b      <= 1'b0;
      mark_c      <= 1'b0;
      busy        <= 1'b0;
      seq_count   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_load) begin
        r_arm   <= arm_dly;
        r_pw    <= pulse_width;
        r_gab   <= gap_ab;
        r_gbc   <= gap_bc;
        r_base  <= baseline;
        r_amp_a <= amp_a;
        r_amp_b <= amp_b;
        r_amp_c <= amp_c;
      end
      adc_data_a  <= {2{(w_next == S_PA) ? sat(w_sum_a) : sat(w_sum_0)}};
      adc_data_b  <= {2{(w_next == S_PB) ? sat(w_sum_b) : sat(w_sum_0)}};
      adc_data_c  <= {2{(w_next == S_PC) ? sat(w_sum_c) : sat(w_sum_0)}};
      adc_valid_a <= gen_enable;
      adc_valid_b <= gen_enable;
      adc_valid_c <= gen_enable;
      mark_a      <= w_next == S_PA;
      mark_b      <= w_next == S_PB;
      mark_c      <= w_next == S_PC;
      busy        <= w_next != S_IDLE;
      seq_count   <= seq_count + 16'(w_next == S_DONE);
    end
  end
endmodule

// File: tb/tb_adc_pulse_pattern_gen.sv
// tb_adc_pulse_pattern_gen: directed and randomized checks against a timeline model of the pulse sequence.
module tb_adc_pulse_pattern_gen;
  logic clk = 0, rstn = 0, gen_enable = 0, gen_start = 0, gen_repeat = 0;
  logic signed [15:0] baseline = 0, amp_a = 0, amp_b = 0, amp_c = 0;
  logic [31:0] arm_dly = 0, pulse_width = 0, gap_ab = 0, gap_bc = 0;
  logic [31:0] adc_data_a, adc_data_b, adc_data_c;
  logic adc_valid_a, adc_valid_b, adc_valid_c, mark_a, mark_b, mark_c, busy;
  logic [15:0] seq_count;
  int checks = 0, errors = 0;

  always #4 clk = ~clk;

  adc_pulse_pattern_gen dut (
    .clk(clk), .rstn(rstn), .gen_enable(gen_enable), .gen_start(gen_start), .gen_repeat(gen_repeat),
    .baseline(baseline), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
    .arm_dly(arm_dly), .pulse_width(pulse_width), .gap_ab(gap_ab), .gap_bc(gap_bc),
    .adc_data_a(adc_data_a), .adc_data_b(adc_data_b), .adc_data_c(adc_data_c),
    .adc_valid_a(adc_valid_a), .adc_valid_b(adc_valid_b), .adc_valid_c(adc_valid_c),
    .mark_a(mark_a), .mark_b(mark_b), .mark_c(mark_c), .busy(busy), .seq_count(seq_count)
  );

  // model: a sequence is a timeline of offsets t since the start edge
  bit m_act, m_en;
  int m_t, m_arm, m_w, m_gab, m_gbc, m_base, m_nz, m_seq;
  int m_amp[3];
  logic [15:0] m_lfsr;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat(int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  function automatic int a0(); return m_arm + 1; endfunction
  function automatic int b0(); return a0() + m_w + m_gab; endfunction
  function automatic int c0(); return b0() + m_w + m_gbc; endfunction
  function automatic int len(); return c0() + m_w + 1; endfunction

  task automatic model_reset();
    m_act = 0; m_en = 0; m_t = 0; m_base = 0; m_nz = 0; m_seq = 0;
    m_arm = 0; m_w = 1; m_gab = 0; m_gbc = 0; m_amp = '{0, 0, 0};
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_edge();
`ifdef PULSE_GEN_NOISE_EN
    m_nz = int'($signed(m_lfsr[3:0]));
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    m_en = gen_enable;
    if (!gen_enable) m_act = 0;
    else if (!m_act) begin
      if (gen_start) begin
        m_act = 1; m_t = 0;
        m_base = int'(baseline);
        m_amp = '{int'(amp_a), int'(amp_b), int'(amp_c)};
        m_arm = int'(arm_dly);
        m_w = (pulse_width == 0) ? 1 : int'(pulse_width);
        m_gab = int'(gap_ab); m_gbc = int'(gap_bc);
      end
    end else begin
      m_t++;
      if (m_t == len()) begin
        if (gen_repeat) m_t = 0;
        else m_act = 0;
      end
    end
    if (m_act && m_t == len() - 1) m_seq = (m_seq + 1) & 16'hFFFF;
  endtask

  task automatic check_outputs();
    bit ma, mb, mc;
    logic [15:0] ea, eb, ec, e0;
    ma = m_act && m_t >= a0() && m_t < a0() + m_w;
    mb = m_act && m_t >= b0() && m_t < b0() + m_w;
    mc = m_act && m_t >= c0() && m_t < c0() + m_w;
    e0 = 16'(sat(m_base + m_nz));
    ea = ma ? 16'(sat(m_base + m_amp[0] + m_nz)) : e0;
    eb = mb ? 16'(sat(m_base + m_amp[1] + m_nz)) : e0;
    ec = mc ? 16'(sat(m_base + m_amp[2] + m_nz)) : e0;
    check("data_a", adc_data_a, {ea, ea});
    check("data_b", adc_data_b, {eb, eb});
    check("data_c", adc_data_c, {ec, ec});
    check("valid", {adc_valid_a, adc_valid_b, adc_valid_c}, {3{m_en}});
    check("mark", {mark_a, mark_b, mark_c}, {ma, mb, mc});
    check("busy", busy, m_act);
    check("seq_count", seq_count, m_seq);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    gen_start = 0;
  endtask

  task automatic cfg(int b, int a, int bb, int c, int arm, int pw, int gab, int gbc);
    baseline = 16'(b); amp_a = 16'(a); amp_b = 16'(bb); amp_c = 16'(c);
    arm_dly = arm; pulse_width = pw; gap_ab = gab; gap_bc = gbc;
  endtask

  initial begin
    int ons[$];
    bit prev;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      check_outputs();
    end
    rstn = 1;
    gen_enable = 1;
    step();
    step();

    cfg(0, 1000, -800, 1200, 3, 4, 10, 6);
    gen_start = 1;
    step();
    for (int i = 1; i <= 36; i++) begin
      step();
`ifndef PULSE_GEN_NOISE_EN
      if (i == 4) check("ss_a_onset", adc_data_a, 32'h03E803E8);
      if (i == 7) check("ss_a_last", adc_data_a, 32'h03E803E8);
      if (i == 8) check("ss_a_end", adc_data_a, 32'h0);
      if (i == 18) check("ss_b_onset", adc_data_b, 32'hFCE0FCE0);
`endif
      if (i == 17) check("ss_b_pre", mark_b, 0);
      if (i == 18) check("ss_b_mark", mark_b, 1);
      if (i == 27) check("ss_c_pre", mark_c, 0);
      if (i == 28) check("ss_c_mark", mark_c, 1);
      if (i == 33) check("ss_seq", seq_count, 1);
      if (i == 33) check("ss_busy", busy, 0);
    end

    cfg(0, 100, 200, 300, 0, 0, 0, 0);
    gen_start = 1;
    step();
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i <= 4) check("bnd_mark", {mark_a, mark_b, mark_c}, 3'b100 >> (i - 1));
    end

    cfg(32000, 1000, 0, 0, 1, 2, 1, 1);
    gen_start = 1;
    step();
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 2 || i == 3) check("sat_a", adc_data_a, 32'h7FFF7FFF);
    end

    cfg(-50, 300, -300, 30000, 2, 3, 1, 2);
    gen_repeat = 1;
    gen_start = 1;
    step();
    prev = 0;
    for (int i = 1; i <= 54; i++) begin
      if (i == 10 || i == 27) begin
        gen_start = 1;
        cfg(5, 5, 5, 5, 9, 9, 9, 9);
      end
      step();
      if (mark_a && !prev) ons.push_back(i);
      prev = mark_a;
    end
    check("rep_onsets", ons.size(), 4);
    for (int j = 1; j < ons.size(); j++) check("rep_period", ons[j] - ons[j-1], 1 + (2 + 1) + 3 * 3 + 1 + 2);
    gen_enable = 0;
    step();
    check("abort_busy", busy, 0);
    check("abort_mark", {mark_a, mark_b, mark_c}, 0);
    for (int i = 0; i < 5; i++) begin
      gen_start = 1;
      step();
    end
    gen_repeat = 0;
    gen_enable = 1;
    step();

    cfg(7, 7, 7, 7, 1, 3, 2, 2);
    gen_start = 1;
    step();
    repeat (6) step();
    @(posedge clk);
    #2 rstn = 0;
    #1;
    check("arst_data", adc_data_a, 0);
    check("arst_mark", {mark_a, mark_b, mark_c}, 0);
    check("arst_busy", busy, 0);
    check("arst_seq", seq_count, 0);
    check("arst_valid", adc_valid_a, 0);
    model_reset();
    @(negedge clk);
    rstn = 1;
    step();

    for (int n = 0; n < 150; n++) begin
      cfg($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
          $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      gen_repeat = $urandom_range(0, 1);
      gen_start = 1;
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 39) == 0) gen_enable = 0;
        else if (!gen_enable && $urandom_range(0, 2) == 0) gen_enable = 1;
        if ($urandom_range(0, 7) == 0) gen_start = 1;
        if ($urandom_range(0, 9) == 0) baseline = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 9) == 0) pulse_width = $urandom_range(0, 4);
        step();
      end
      gen_enable = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
